sobel_frame_arbiter: RTL
========================

# sobel_frame_arbiter

Frame-granular round-robin arbiter that shares the single Sobel input FIFO between two pixel sources (e.g. two camera/decoder streams). It sits between two upstream first-word-fall-through read FIFOs and the write side of the FIFO feeding `sobel`. Grants are held for exactly one full frame (IMG_WIDTH×IMG_HEIGHT pixels), so `sobel` never sees pixels of two frames interleaved.

## Interface
- IMG_WIDTH, 720, pixels per line
- IMG_HEIGHT, 540, lines per frame
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in0_rd_en  out  1  read strobe to source-0 FIFO (combinational)
- in0_dout  in  8  source-0 pixel (FWFT, valid when !in0_empty)
- in0_empty  in  1  source-0 FIFO empty
- in1_rd_en  out  1  read strobe to source-1 FIFO (combinational)
- in1_dout  in  8  source-1 pixel
- in1_empty  in  1  source-1 FIFO empty
- out_wr_en  out  1  write strobe to Sobel input FIFO (combinational)
- out_din  out  8  pixel to Sobel input FIFO (combinational)
- out_full  in  1  Sobel input FIFO full
- grant  out  2  registered one-hot owner: 01 = src0, 10 = src1, 00 = none
- frame_done  out  1  registered one-cycle pulse after a frame's last pixel is written
- frame_cnt0, frame_cnt1  out  16 each  completed-frame counters per source, wrap at 65535→0

## Operation
- FRAME = IMG_WIDTH*IMG_HEIGHT; pixel counter `pix` is 20 bits (holds up to 1,048,575), compares against FRAME-1.
- State IDLE (grant=00):
  - no reads, no writes
  - if only one source non-empty → grant it, go XFER
  - if both non-empty → grant the source named by `prio`, go XFER
  - if both empty → stay IDLE
- State XFER (grant one-hot to src k):
  - xfer = !ink_empty && !out_full
  - ink_rd_en = out_wr_en = xfer; out_din = ink_dout; other source's rd_en = 0
  - on xfer: pix += 1
  - on xfer with pix == FRAME-1:
    - pix ← 0
    - frame_cnt_k += 1
    - prio ← other source
    - grant ← 00, next state IDLE
    - frame_done = 1 on the next cycle
  - empty or full stalls only; grant is never released mid-frame, even when the granted source stays empty indefinitely
- out_din = 8'h00 whenever out_wr_en = 0.
- `prio` flips only on frame completion, never in IDLE; a lone active source therefore gets consecutive frames.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state IDLE, grant=00, prio=src0, pix=0
  - frame_cnt0=frame_cnt1=0, frame_done=0
  - all rd_en/wr_en=0, out_din=0
- Reset asserted mid-frame aborts the frame: partial pixels already written are not retracted, counters do not increment, and after release arbitration restarts from IDLE with prio=src0.
- Arbitration latency: one cycle in IDLE. A source non-empty at edge t gets grant visible after edge t+1; its first pixel write occurs in cycle t+1.
- Throughput: with no stalls, a frame occupies FRAME XFER cycles plus one IDLE cycle; back-to-back frames therefore cost FRAME+1 cycles each.
- Handshake: rd_en and wr_en are combinational from registered state and current empty/full, and are asserted in the same cycle (zero-latency pass-through, no internal buffering).
- frame_done is high exactly one cycle, coincident with the IDLE cycle after completion; frame_cnt updates in that same cycle.
- out_full and ink_empty both asserted in the same cycle: no transfer and no counter change.

## Test plan
(Bench params IMG_WIDTH=4, IMG_HEIGHT=3, so FRAME=12.)
- Reset then src0 loaded with 12 pixels 0x01..0x0C, src1 empty → grant=01 one cycle later, out_din sequence 0x01..0x0C on 12 consecutive wr_en, frame_done pulse, frame_cnt0=1, grant=00.
- Both sources loaded with 24 pixels each (src0 0x10.., src1 0x80..) → frames granted src0, src1, src0, src1; each frame 12 writes; frame_cnt0=frame_cnt1=2; total 52 cycles from first grant to last frame_done with no stalls.
- src0 frame in progress, out_full held high 5 cycles after pixel 6 → no rd_en/wr_en during those cycles, pix holds at 6, resume with pixel 7, grant stays 01, no src1 pixel interleaved.
- src0 drains to empty after 7 pixels while src1 is full → grant stays 01, no src1 reads; refill src0 with 5 pixels → frame completes, then src1 granted.
- reset pulsed low for 1 cycle after 8 pixels of src1's frame → all outputs return to reset values immediately, frame_cnt1 stays 0, next grant goes to src0 if both are non-empty.
- frame_cnt0 preloaded via 65535 completions (or forced) → next completion wraps frame_cnt0 to 0.

Source files
------------

// File: rtl/sobel_frame_arbiter.sv
// sobel_frame_arbiter: frame-granular round-robin arbiter that merges two
// FWFT pixel sources into the single Sobel input FIFO. Ownership is held for
// one complete frame so the downstream filter never sees interleaved frames.
module sobel_frame_arbiter #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in0_rd_en,
  input  logic [7:0]  in0_dout,
  input  logic        in0_empty,
  output logic        in1_rd_en,
  input  logic [7:0]  in1_dout,
  input  logic        in1_empty,
  output logic        out_wr_en,
  output logic [7:0]  out_din,
  input  logic        out_full,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1
);

  localparam logic [19:0] LAST_PIX = 20'(IMG_WIDTH * IMG_HEIGHT - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic        prio_reg, prio_next;      // 0 = src0 wins a tie, 1 = src1
  logic [19:0] pix_reg, pix_next;
  logic        frame_done_reg, done_next;
  logic [15:0] frame_cnt0_reg, frame_cnt1_reg;
  logic        xfer;

  // Arbitration, pass-through handshake and pixel/frame bookkeeping
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    prio_next  = prio_reg;
    pix_next   = pix_reg;
    done_next  = 1'b0;
    in0_rd_en  = 1'b0;
    in1_rd_en  = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = 8'h00;
    xfer       = 1'b0;
    case (state_reg)
      IDLE: begin
        // A lone active source always wins; prio only breaks ties.
        if (!in0_empty && (in1_empty || !prio_reg)) begin
          grant_next = 2'b01;
          state_next = XFER;
        end else if (!in1_empty) begin
          grant_next = 2'b10;
          state_next = XFER;
        end
      end
      XFER: begin
        if (grant_reg[0]) begin
          xfer      = !in0_empty && !out_full;
          in0_rd_en = xfer;
          if (xfer) out_din = in0_dout;
        end else begin
          xfer      = !in1_empty && !out_full;
          in1_rd_en = xfer;
          if (xfer) out_din = in1_dout;
        end
        out_wr_en = xfer;
        // Empty/full only stall; ownership ends solely on the frame's last pixel.
        if (xfer) begin
          if (pix_reg == LAST_PIX) begin
            pix_next   = 20'd0;
            prio_next  = grant_reg[0];   // hand priority to the other source
            grant_next = 2'b00;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            pix_next = pix_reg + 20'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, ownership, priority and pixel-position registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 2'b00;
      prio_reg       <= 1'b0;
      pix_reg        <= 20'd0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      prio_reg       <= prio_next;
      pix_reg        <= pix_next;
      frame_done_reg <= done_next;
    end
  end

  // Per-source completed-frame counters, wrapping naturally at 16 bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt0_reg <= 16'd0;
      frame_cnt1_reg <= 16'd0;
    end else if (done_next) begin
      if (grant_reg[0]) frame_cnt0_reg <= frame_cnt0_reg + 16'd1;
      else              frame_cnt1_reg <= frame_cnt1_reg + 16'd1;
    end
  end

  assign grant      = grant_reg;
  assign frame_done = frame_done_reg;
  assign frame_cnt0 = frame_cnt0_reg;
  assign frame_cnt1 = frame_cnt1_reg;

endmodule
